// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side write handshake and serial line of the UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] data_in;
  logic                      rdy;
  logic                      busy;
  logic                      tx;

  // Host: issues writes and observes status and the line.
  modport master (
    output wr_en,
    output data_in,
    input  rdy,
    input  busy,
    input  tx
  );

  // Transmitter: accepts writes and drives status and the line.
  modport slave (
    input  wr_en,
    input  data_in,
    output rdy,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: 8-bit LSB-first frames with a one-deep holding register.
// Bit timing counts pulses of the shared 16x oversample strobe clk_en.
// Optional even parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  uart_transmitter_if.slave  bus
);

  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned IDX_W    = 3;

  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0]    DATA_LAST   = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0]    STOP_LAST   = IDX_W'(STOP_BITS - 1);

  uart_state_e               state_q,  state_d;
  logic [SAMPLE_W-1:0]       sample_q, sample_d;
  logic [IDX_W-1:0]          idx_q,    idx_d;
  logic [UART_DATA_BITS-1:0] hold_q,   hold_d;
  logic [UART_DATA_BITS-1:0] shift_q,  shift_d;
  logic                      rdy_q,    rdy_d;
  logic                      busy_q,   busy_d;
  logic                      tx_q,     tx_d;

  logic bit_end;
  logic load;

  // Next-state logic: write handshake, bit timing, frame sequencing and line level.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    rdy_d    = rdy_q;
    load     = 1'b0;
    bit_end  = clk_en && (sample_q == SAMPLE_LAST);

    // rdy doubles as the holding-register-empty flag; writes while full drop.
    if (bus.wr_en && rdy_q) begin
      hold_d = bus.data_in;
      rdy_d  = 1'b0;
    end

    if ((state_q != ST_IDLE) && clk_en) begin
      sample_d = bit_end ? '0 : sample_q + SAMPLE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        load = !rdy_q;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
`endif
      ST_STOP: begin
        // idx counts stop bits here so two stop bits reuse the same bit timer
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            if (!rdy_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // Holding register to shift register; no write can collide since rdy is 0.
    if (load) begin
      shift_d  = hold_q;
      rdy_d    = 1'b1;
      sample_d = '0;
      idx_d    = '0;
      state_d  = ST_START;
    end

    // Line level follows the state being entered so tx stays registered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = uart_even_parity(shift_d);
`endif
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.rdy  = rdy_q;
  assign bus.busy = busy_q;
  assign bus.tx   = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_en = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_transmitter_if u_if ();
  uart_transmitter_if u_if2 ();

  uart_transmitter #(.SAMPLES_PER_BIT(16), .STOP_BITS(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (u_if)
  );

  uart_transmitter #(.SAMPLES_PER_BIT(16), .STOP_BITS(2)) dut2 (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (u_if2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame bit i: start, 8 data LSB first, parity, stops.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (PAR == 1 && i == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic int frame_bits(input int stops);
    return 9 + PAR + stops;
  endfunction

  // Write from IDLE and step to the first START cycle.
  task automatic start_frame(input logic [7:0] d, input string name);
    u_if.wr_en   = 1'b1;
    u_if.data_in = d;
    step();
    u_if.wr_en = 1'b0;
    tests_run++;
    if (u_if.rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s write rdy: got %b expected 0", name, u_if.rdy);
    end
    step();
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b011) begin
      tests_failed++;
      $display("FAIL %s load tx/busy/rdy: got %b%b%b expected 011", name,
               u_if.tx, u_if.busy, u_if.rdy);
    end
  endtask

  // Walk frame cycles t0..t1-1, driving clk_en every `period` cycles.
  task automatic run_frame(input logic [7:0] d, input int period, input int t0,
                           input int t1, input string name);
    int cpb;
    logic e;
    cpb = 16 * period;
    for (int t = t0; t < t1; t++) begin
      clk_en = ((t + 1) % period == 0);
      e = exp_bit(d, t / cpb);
      tests_run++;
      if ({u_if.tx, u_if.busy} !== {e, 1'b1}) begin
        tests_failed++;
        $display("FAIL %s cycle %0d tx/busy: got %b%b expected %b1", name, t,
                 u_if.tx, u_if.busy, e);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL reset tx/busy/rdy: got %b%b%b expected 101", u_if.tx, u_if.busy, u_if.rdy);
    end
    tests_run++;
    if ({u_if2.tx, u_if2.busy, u_if2.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL reset2 tx/busy/rdy: got %b%b%b expected 101", u_if2.tx, u_if2.busy, u_if2.rdy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    int n;
    n = 16 * frame_bits(1);
    clk_en = 1'b1;
    start_frame(8'hA5, "a5");
    run_frame(8'hA5, 1, 0, n, "a5");
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL a5 end tx/busy/rdy: got %b%b%b expected 101", u_if.tx, u_if.busy, u_if.rdy);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    clk_en = 1'b1;
    start_frame(8'h01, "par01");
    run_frame(8'h01, 1, 0, 176, "par01");
    tests_run++;
    if ({u_if.tx, u_if.busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL par01 end at 176: got tx/busy %b%b expected 10", u_if.tx, u_if.busy);
    end
    start_frame(8'hA5, "parA5");
    run_frame(8'hA5, 1, 0, 176, "parA5");
    tests_run++;
    if ({u_if.tx, u_if.busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL parA5 end at 176: got tx/busy %b%b expected 10", u_if.tx, u_if.busy);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int n;
    n = 16 * frame_bits(1);
    clk_en = 1'b1;
    start_frame(8'h00, "b2b0");
    u_if.wr_en   = 1'b1;
    u_if.data_in = 8'hFF;
    step();
    tests_run++;
    if (u_if.rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b queued rdy: got %b expected 0", u_if.rdy);
    end
    u_if.data_in = 8'h11;
    step();
    u_if.wr_en = 1'b0;
    tests_run++;
    if (u_if.rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b dropped rdy: got %b expected 0", u_if.rdy);
    end
    run_frame(8'h00, 1, 2, n, "b2b0");
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b011) begin
      tests_failed++;
      $display("FAIL b2b reload tx/busy/rdy: got %b%b%b expected 011", u_if.tx, u_if.busy, u_if.rdy);
    end
    run_frame(8'hFF, 1, 0, n, "b2bFF");
    for (int i = 0; i < 200; i++) begin
      tests_run++;
      if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b101) begin
        tests_failed++;
        $display("FAIL b2b idle cycle %0d tx/busy/rdy: got %b%b%b expected 101", i,
                 u_if.tx, u_if.busy, u_if.rdy);
      end
      step();
    end
  endtask

  task automatic test_slow_strobe();
    int n;
    n = 64 * frame_bits(1);
    clk_en = 1'b0;
    start_frame(8'h96, "slow");
    run_frame(8'h96, 4, 0, n, "slow");
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL slow end tx/busy/rdy: got %b%b%b expected 101", u_if.tx, u_if.busy, u_if.rdy);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    clk_en = 1'b1;
    start_frame(8'h3C, "rstmid");
    u_if.wr_en   = 1'b1;
    u_if.data_in = 8'h55;
    step();
    u_if.wr_en = 1'b0;
    tests_run++;
    if (u_if.rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid queued rdy: got %b expected 0", u_if.rdy);
    end
    run_frame(8'h3C, 1, 1, 4 * 16 + 5, "rstmid");
    rst = 1'b1;
    step();
    tests_run++;
    if ({u_if.tx, u_if.busy, u_if.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL rstmid after reset tx/busy/rdy: got %b%b%b expected 101", u_if.tx, u_if.busy, u_if.rdy);
    end
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      tests_run++;
      if ({u_if.tx, u_if.busy} !== 2'b10) begin
        tests_failed++;
        $display("FAIL rstmid idle cycle %0d tx/busy: got %b%b expected 10", i, u_if.tx, u_if.busy);
      end
    end
  endtask

  task automatic test_two_stop();
    int n;
    logic e;
    n = 16 * frame_bits(2);
    clk_en = 1'b1;
    u_if2.wr_en   = 1'b1;
    u_if2.data_in = 8'h80;
    step();
    u_if2.wr_en = 1'b0;
    step();
    for (int t = 0; t < n; t++) begin
      e = exp_bit(8'h80, t / 16);
      tests_run++;
      if ({u_if2.tx, u_if2.busy} !== {e, 1'b1}) begin
        tests_failed++;
        $display("FAIL stop2 cycle %0d tx/busy: got %b%b expected %b1", t, u_if2.tx, u_if2.busy, e);
      end
      step();
    end
    tests_run++;
    if ({u_if2.tx, u_if2.busy, u_if2.rdy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL stop2 end tx/busy/rdy: got %b%b%b expected 101", u_if2.tx, u_if2.busy, u_if2.rdy);
    end
  endtask

  initial begin
    u_if.wr_en    = 1'b0;
    u_if.data_in  = 8'h00;
    u_if2.wr_en   = 1'b0;
    u_if2.data_in = 8'h00;
    test_reset();
    test_single_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_slow_strobe();
    test_reset_mid_frame();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
